// File: rtl/fft_pkg.sv
// Shared types for the FFT frame decimator: frame-tracker state encoding and counter widths.
// Pure declarations; no logic, latency or flow control here.
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_SKIP = 2'd2
  } fft_state_t;

  localparam int FRAMES_KEPT_W = 16;

endpackage

// File: rtl/fft_frame_tracker.sv
// Tracks bin/frame position and flags each input sample as keep/last/misaligned (combinational on in_valid).
// No backpressure: every in_valid sample is consumed in its cycle.
module fft_frame_tracker
  import fft_pkg::*;
#(
  parameter int FRAME_LEN   = 128,
  parameter int RATIO_WIDTH = 8,
  parameter int BIN_W       = $clog2(FRAME_LEN)
) (
  input  logic                   clock_50,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic                   in_sop,
  input  logic [RATIO_WIDTH-1:0] decim_ratio,
  output logic                   keep,
  output logic                   last,
  output logic                   misaligned,
  output logic [BIN_W-1:0]       bin
);

  localparam logic [BIN_W-1:0] BIN_LAST = BIN_W'(FRAME_LEN - 1);

  fft_state_t             state, state_nxt;
  logic [BIN_W-1:0]       bin_cnt, bin_nxt;
  logic [RATIO_WIDTH-1:0] frame_cnt, fc_nxt, fc_adv;
  logic [RATIO_WIDTH-1:0] r_latched, r_nxt;
  logic [RATIO_WIDTH-1:0] start_fc;
  logic                   start;
  logic                   sop_in;

  always_ff @(posedge clock_50) begin
    if (reset) begin
      state     <= ST_IDLE;
      bin_cnt   <= '0;
      frame_cnt <= '0;
      r_latched <= '0;
    end else begin
      state     <= state_nxt;
      bin_cnt   <= bin_nxt;
      frame_cnt <= fc_nxt;
      r_latched <= r_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    bin_nxt    = bin_cnt;
    fc_nxt     = frame_cnt;
    r_nxt      = r_latched;
    keep       = 1'b0;
    last       = 1'b0;
    misaligned = 1'b0;
    bin        = bin_cnt;
    start      = 1'b0;
    start_fc   = frame_cnt;
    sop_in     = in_valid & in_sop;
    fc_adv     = (frame_cnt >= r_latched) ? '0 : frame_cnt + RATIO_WIDTH'(1);

    case (state)
      ST_IDLE: begin
        if (sop_in) begin
          start = 1'b1;
          bin   = '0;
        end
      end
      ST_PASS, ST_SKIP: begin
        if (sop_in) begin
          // Abandoned frame still counts toward decimation before the new sop is judged.
          misaligned = 1'b1;
          start      = 1'b1;
          start_fc   = fc_adv;
          fc_nxt     = fc_adv;
          bin        = '0;
        end else if (in_valid) begin
          keep = (state == ST_PASS);
          if (bin_cnt == BIN_LAST) begin
            last      = 1'b1;
            fc_nxt    = fc_adv;
            state_nxt = ST_IDLE;
            bin_nxt   = '0;
          end else begin
            bin_nxt = bin_cnt + BIN_W'(1);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (start) begin
      bin_nxt = BIN_W'(1);
      if (start_fc == '0) begin
        state_nxt = ST_PASS;
        keep      = 1'b1;
        r_nxt     = decim_ratio;
      end else begin
        state_nxt = ST_SKIP;
      end
    end
  end

endmodule

// File: rtl/fft_frame_decimator.sv
// Keeps one FFT frame in every decim_ratio+1; kept samples leave exactly 1 cycle after input.
// No backpressure: output is a registered copy of the input stream with its gaps preserved.
module fft_frame_decimator
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAME_LEN   = 128,
  parameter int RATIO_WIDTH = 8
) (
  input  logic                         clock_50,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic                         in_sop,
  input  logic [DATA_WIDTH-1:0]        in_real,
  input  logic [DATA_WIDTH-1:0]        in_imag,
  input  logic [RATIO_WIDTH-1:0]       decim_ratio,
  output logic                         out_valid,
  output logic                         out_sop,
  output logic                         out_eop,
  output logic [DATA_WIDTH-1:0]        out_real,
  output logic [DATA_WIDTH-1:0]        out_imag,
  output logic [$clog2(FRAME_LEN)-1:0] out_bin,
  output logic                         frame_err,
  output logic [FRAMES_KEPT_W-1:0]     frames_kept
);

  localparam int BIN_W = $clog2(FRAME_LEN);

  logic             keep, last, misaligned;
  logic [BIN_W-1:0] bin;

  fft_frame_tracker #(
    .FRAME_LEN  (FRAME_LEN),
    .RATIO_WIDTH(RATIO_WIDTH),
    .BIN_W      (BIN_W)
  ) u_tracker (
    .clock_50   (clock_50),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_sop     (in_sop),
    .decim_ratio(decim_ratio),
    .keep       (keep),
    .last       (last),
    .misaligned (misaligned),
    .bin        (bin)
  );

  always_ff @(posedge clock_50) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_sop     <= 1'b0;
      out_eop     <= 1'b0;
      out_real    <= '0;
      out_imag    <= '0;
      out_bin     <= '0;
      frame_err   <= 1'b0;
      frames_kept <= '0;
    end else begin
      out_valid <= keep;
      out_sop   <= keep && (bin == '0);
      out_eop   <= keep && last;
      frame_err <= misaligned;
      // Sample payload holds through idle cycles.
      if (keep) begin
        out_bin  <= bin;
        out_real <= in_real;
        out_imag <= in_imag;
      end
      if (keep && last) frames_kept <= frames_kept + FRAMES_KEPT_W'(1);
    end
  end

endmodule

// File: tb/tb_fft_frame_decimator.sv
// Directed bench for fft_frame_decimator: frame streams with known keep patterns, gaps, misaligned sop, mid-frame reset.
module tb_fft_frame_decimator;

  localparam int FL = 128;

  logic        clock_50 = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_sop = 1'b0;
  logic [15:0] in_real = '0;
  logic [15:0] in_imag = '0;
  logic [7:0]  decim_ratio = '0;
  logic        out_valid, out_sop, out_eop, frame_err;
  logic [15:0] out_real, out_imag;
  logic [6:0]  out_bin;
  logic [15:0] frames_kept;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [15:0] last_re = '0;
  logic [15:0] last_im = '0;
  logic [9:0]  mask10;
  logic [8:0]  mask9;

  fft_frame_decimator #(
    .DATA_WIDTH (16),
    .FRAME_LEN  (FL),
    .RATIO_WIDTH(8)
  ) dut (
    .clock_50   (clock_50),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_sop     (in_sop),
    .in_real    (in_real),
    .in_imag    (in_imag),
    .decim_ratio(decim_ratio),
    .out_valid  (out_valid),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .out_real   (out_real),
    .out_imag   (out_imag),
    .out_bin    (out_bin),
    .frame_err  (frame_err),
    .frames_kept(frames_kept)
  );

  always #5 clock_50 = ~clock_50;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_50);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b1;
    in_sop   = 1'b1;
    in_real  = 16'h1234;
    in_imag  = 16'h5678;
    tick();
    tick();
    check("rst", {out_valid, out_sop, out_eop, frame_err, out_bin, out_real, out_imag, frames_kept}, 64'd0);
    reset    = 1'b0;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    last_re  = '0;
    last_im  = '0;
  endtask

  // n samples starting at bin 0; kept says whether this frame must appear on the output.
  task automatic send_frame(input int n, input bit kept, input bit gaps, input bit err_first,
                            input logic [15:0] base, input int chg_at, input logic [7:0] chg_val);
    logic [15:0] re;
    for (int i = 0; i < n; i++) begin
      re = base + 16'(i);
      if (i == chg_at) decim_ratio = chg_val;
      in_valid = 1'b1;
      in_sop   = (i == 0);
      in_real  = re;
      in_imag  = ~re;
      tick();
      check("vld", {out_valid, frame_err}, {kept, err_first && (i == 0)});
      if (kept) begin
        check("smp", {out_sop, out_eop, out_bin, out_real, out_imag},
              {i == 0, i == FL - 1, 7'(i), re, ~re});
        last_re = re;
        last_im = ~re;
      end
      if (gaps) begin
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_real  = 16'hDEAD;
        in_imag  = 16'hBEEF;
        tick();
        check("gap", {out_valid, out_real, out_imag}, {1'b0, last_re, last_im});
      end
    end
    in_valid = 1'b0;
    in_sop   = 1'b0;
  endtask

  initial begin
    // R=0: three contiguous frames, all kept.
    decim_ratio = 8'd0;
    do_reset();
    for (int f = 0; f < 3; f++) send_frame(FL, 1'b1, 1'b0, 1'b0, 16'(f * 1000), -1, 8'd0);
    check("kept_r0", frames_kept, 16'd3);

    // R=3: ten frames, frames 0,4,8 kept.
    decim_ratio = 8'd3;
    do_reset();
    mask10 = 10'b01_0001_0001;
    for (int f = 0; f < 10; f++) send_frame(FL, mask10[f], 1'b0, 1'b0, 16'(f * 256), -1, 8'd0);
    check("kept_r3", frames_kept, 16'd3);

    // R=1 with in_valid toggling; frame 1 fully suppressed, gaps hold last payload.
    decim_ratio = 8'd1;
    do_reset();
    send_frame(FL, 1'b1, 1'b1, 1'b0, 16'h4000, -1, 8'd0);
    send_frame(FL, 1'b0, 1'b1, 1'b0, 16'h5000, -1, 8'd0);
    check("kept_gap", frames_kept, 16'd1);

    // R=1, sop re-asserted at bin 50: error, new frame skipped, following frame kept.
    decim_ratio = 8'd1;
    do_reset();
    send_frame(50, 1'b1, 1'b0, 1'b0, 16'h0100, -1, 8'd0);
    send_frame(FL, 1'b0, 1'b0, 1'b1, 16'h0200, -1, 8'd0);
    check("kept_mis", frames_kept, 16'd0);
    send_frame(FL, 1'b1, 1'b0, 1'b0, 16'h0300, -1, 8'd0);
    check("kept_mis2", frames_kept, 16'd1);

    // Ratio 0 -> 2 mid frame 1: frames 0,1,2 kept, then 5 and 8.
    decim_ratio = 8'd0;
    do_reset();
    mask9 = 9'b1_0010_0111;
    for (int f = 0; f < 9; f++)
      send_frame(FL, mask9[f], 1'b0, 1'b0, 16'(f * 300), (f == 1) ? 64 : -1, 8'd2);
    check("kept_chg", frames_kept, 16'd5);

    // Reset at bin 60 of a kept frame.
    decim_ratio = 8'd0;
    do_reset();
    send_frame(60, 1'b1, 1'b0, 1'b0, 16'h7000, -1, 8'd0);
    in_valid = 1'b1;
    in_sop   = 1'b0;
    in_real  = 16'h7777;
    in_imag  = 16'h8888;
    reset    = 1'b1;
    tick();
    check("rst_mid", {out_valid, out_sop, out_eop, frame_err, out_bin, out_real, out_imag, frames_kept}, 64'd0);
    reset    = 1'b0;
    in_valid = 1'b0;
    last_re  = '0;
    last_im  = '0;
    tick();
    check("rst_idle", {out_valid, frame_err}, 2'b00);
    send_frame(FL, 1'b1, 1'b0, 1'b0, 16'h7100, -1, 8'd0);
    check("kept_rst", frames_kept, 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fft_frame_decimator.md
FFT_FRAME_DECIMATOR -- requirements
Module: fft_frame_decimator

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of each real/imag sample.
REQ-002 Parameter FRAME_LEN, default 128, samples (bins) per FFT frame; power of two, 8..4096.
REQ-003 Parameter RATIO_WIDTH, default 8, width of decim_ratio.
REQ-004 clock_50  input  1  single system clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  input sample strobe; one sample per asserted cycle.
REQ-007 in_sop  input  1  first sample of a frame; qualified by in_valid.
REQ-008 in_real / in_imag  input  DATA_WIDTH each  input sample, two's complement.
REQ-009 decim_ratio  input  RATIO_WIDTH  R; one frame kept out of every R+1.
REQ-010 out_valid  output  1  output sample strobe.
REQ-011 out_sop / out_eop  output  1 each  first/last sample of a kept frame; qualified by out_valid.
REQ-012 out_real / out_imag  output  DATA_WIDTH each  kept sample, unmodified.
REQ-013 out_bin  output  clog2(FRAME_LEN)  bin index of the current output sample.
REQ-014 frame_err  output  1  one-cycle pulse on a frame-alignment error.
REQ-015 frames_kept  output  16  count of complete frames emitted; wraps at 65535.

Function
REQ-016 The block has three states: IDLE (wait for in_sop), PASS (forward the frame), SKIP (discard the frame).
REQ-017 IDLE -> PASS or SKIP on in_valid&in_sop, chosen by frame_cnt==0 (PASS) or frame_cnt!=0 (SKIP); in_valid without in_sop in IDLE is discarded.
REQ-018 bin_cnt counts in_valid samples within the frame, from 0 (sop sample) to FRAME_LEN-1.
REQ-019 On the sample with bin_cnt==FRAME_LEN-1, frame_cnt advances: to 0 if frame_cnt>=R_latched, otherwise +1; the state returns to IDLE.
REQ-020 R_latched is captured from decim_ratio only on the sop sample entering the frame-0 decision; mid-cycle changes take effect at the next frame_cnt==0 boundary.
REQ-021 R=0 passes every frame; R=3 passes frames 0,4,8,...
REQ-022 In PASS, each accepted sample appears on the outputs exactly 1 cycle later with out_valid=1; out_bin=bin_cnt; out_sop at bin 0; out_eop at bin FRAME_LEN-1.
REQ-023 out_valid is 0 in every cycle with no forwarded sample; gaps in in_valid are reproduced on the output.
REQ-024 out_real/out_imag hold their last value when out_valid=0.
REQ-025 frames_kept increments in the same cycle that out_eop is asserted.
REQ-026 in_valid&in_sop while in PASS or SKIP with bin_cnt!=0 is a misaligned sop: pulse frame_err 1 cycle later and abandon the current frame (no out_eop, no frames_kept increment).
REQ-027 The abandoned frame counts as a frame for frame_cnt (advance per REQ-019), and the sop sample then starts a new frame decided by the updated frame_cnt, in the same cycle.
REQ-028 A frame whose final sample is never received stays in PASS/SKIP indefinitely; there is no timeout.

Reset
REQ-029 While reset=1: state=IDLE, bin_cnt=0, frame_cnt=0, R_latched=0, frames_kept=0, out_valid=0, out_sop=0, out_eop=0, frame_err=0, out_real=0, out_imag=0, out_bin=0.
REQ-030 reset overrides in_valid in the same cycle; a frame in progress is discarded without frame_err, and the first sop after reset goes to PASS.

Structure
REQ-031 The state encoding (IDLE/PASS/SKIP) and the frames_kept width constant belong in the shared package fft_pkg.
REQ-032 One sub-module, fft_frame_tracker, holds bin_cnt, frame_cnt, and R_latched and emits the keep/last/misaligned flags; the top module holds the output register stage.

Verification
REQ-033 R=0, FRAME_LEN=128, 3 contiguous frames -> 384 out_valid cycles, each 1 cycle after input, out_sop at bins 0, out_eop at bins 127, frames_kept=3.
REQ-034 R=3, 10 frames with ramp data -> frames 0,4,8 emitted bit-exact, frames_kept=3, no output during the other frames.
REQ-035 R=1, in_valid toggling 1010... -> output reproduces the same gaps with 1-cycle latency; frame 1 is fully suppressed.
REQ-036 in_sop re-asserted at bin 50 of a kept frame (R=1) -> frame_err pulse, no out_eop, frames_kept unchanged, new frame skipped (frame_cnt=1).
REQ-037 decim_ratio changed from 0 to 2 mid-frame 1 -> frame 2 still passes under R=0; after frame 2, frames pass 1 in 3.
REQ-038 reset asserted at bin 60 of a kept frame -> all outputs 0 next cycle, no frame_err, next sop frame passes.
